// File: rtl/nios2_system_dpram_ctrl.sv
// Dual-port Avalon-MM on-chip RAM controller.
// Post-reset zero fill, pipelined reads, same-address write arbitration.
module nios2_system_dpram_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 14,
  parameter int DEPTH          = 10240,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    chipselect,
  input  logic                    read,
  input  logic                    write,
  input  logic [ADDR_WIDTH-1:0]   address,
  input  logic [DATA_WIDTH/8-1:0] byteenable,
  input  logic [DATA_WIDTH-1:0]   writedata,
  output logic                    waitrequest,
  output logic [DATA_WIDTH-1:0]   readdata,
  output logic                    readdatavalid,
  input  logic                    chipselect2,
  input  logic                    read2,
  input  logic                    write2,
  input  logic [ADDR_WIDTH-1:0]   address2,
  input  logic [DATA_WIDTH/8-1:0] byteenable2,
  input  logic [DATA_WIDTH-1:0]   writedata2,
  output logic                    waitrequest2,
  output logic [DATA_WIDTH-1:0]   readdata2,
  output logic                    readdatavalid2,
  output logic                    busy,
  output logic                    range_err
);

  localparam int BW = DATA_WIDTH / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] RESET_WAIT = 2'd0;
  localparam logic [1:0] CLEAR      = 2'd1;
  localparam logic [1:0] READY      = 2'd2;

  logic [1:0]            state;
  logic [IW-1:0]         clr_cnt;
  logic                  col_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic ready, collide, acc1, acc2, in1, in2;
  logic wr_en1, wr_en2, rd_en1, rd_en2;
  logic [IW-1:0] idx1, idx2;
  logic [DATA_WIDTH-1:0] rd_word1, rd_word2;

  assign ready = (state == READY);
  assign busy  = ~ready;

  // s2 yields for one cycle only; col_q lets its held write through next.
  assign collide = ready & chipselect & write
                 & chipselect2 & write2
                 & (address == address2) & ~col_q;

  assign waitrequest  = ~ready;
  assign waitrequest2 = ~ready | collide;

  assign acc1 = ready & chipselect & (read | write);
  assign acc2 = ready & ~collide & chipselect2 & (read2 | write2);

  assign in1 = 32'(address) < DEPTH;
  assign in2 = 32'(address2) < DEPTH;
  assign idx1 = address[IW-1:0];
  assign idx2 = address2[IW-1:0];

  assign wr_en1 = acc1 & write & in1;
  assign wr_en2 = acc2 & write2 & in2;
  assign rd_en1 = acc1 & read & ~write;
  assign rd_en2 = acc2 & read2 & ~write2;

  assign rd_word1 = in1 ? mem[idx1] : '0;
  assign rd_word2 = in2 ? mem[idx2] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= RESET_WAIT;
      clr_cnt   <= '0;
      col_q     <= 1'b0;
      range_err <= 1'b0;
    end else begin
      case (state)
        RESET_WAIT:
          state <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
        CLEAR: begin
          if (clr_cnt == IW'(DEPTH - 1)) begin
            state   <= READY;
            clr_cnt <= '0;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        READY:   state <= READY;
        default: state <= RESET_WAIT;
      endcase
      col_q <= collide;
      if ((acc1 & ~in1) | (acc2 & ~in2))
        range_err <= 1'b1;
    end
  end

  // s2 is applied last so its data wins a same-address double write.
  always_ff @(posedge clk) begin
    if (state == CLEAR)
      mem[clr_cnt] <= '0;
    for (int b = 0; b < BW; b++) begin
      if (wr_en1 && byteenable[b])
        mem[idx1][b*8 +: 8] <= writedata[b*8 +: 8];
      if (wr_en2 && byteenable2[b])
        mem[idx2][b*8 +: 8] <= writedata2[b*8 +: 8];
    end
  end

  logic                  p1_v, p2_v, o1_v, o2_v;
  logic [DATA_WIDTH-1:0] p1_d, p2_d, o1_d, o2_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p1_v <= 1'b0;
      p2_v <= 1'b0;
      o1_v <= 1'b0;
      o2_v <= 1'b0;
      p1_d <= '0;
      p2_d <= '0;
      o1_d <= '0;
      o2_d <= '0;
    end else begin
      p1_v <= rd_en1;
      p2_v <= rd_en2;
      if (rd_en1) p1_d <= rd_word1;
      if (rd_en2) p2_d <= rd_word2;
      o1_v <= p1_v;
      o2_v <= p2_v;
      if (p1_v) o1_d <= p1_d;
      if (p2_v) o2_d <= p2_d;
    end
  end

  assign readdatavalid  = (READ_LATENCY == 2) ? o1_v : p1_v;
  assign readdatavalid2 = (READ_LATENCY == 2) ? o2_v : p2_v;
  assign readdata       = (READ_LATENCY == 2) ? o1_d : p1_d;
  assign readdata2      = (READ_LATENCY == 2) ? o2_d : p2_d;

endmodule

// File: tb/tb_nios2_system_dpram_ctrl.sv
// Bench for nios2_system_dpram_ctrl: directed table, random traffic,
// reset corner cases, all checked against a word-array model.
module tb_nios2_system_dpram_ctrl;

  localparam int DW  = 32;
  localparam int AW  = 5;
  localparam int DEP = 16;
  localparam int RL  = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic          cs1, rd1, wr1, cs2, rd2, wr2;
  logic [AW-1:0] a1, a2;
  logic [3:0]    be1, be2;
  logic [DW-1:0] wd1, wd2;
  logic          wq1, wq2, rdv1, rdv2, busy, rerr;
  logic [DW-1:0] rdd1, rdd2;

  nios2_system_dpram_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEP),
    .READ_LATENCY(RL), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .chipselect(cs1), .read(rd1), .write(wr1),
    .address(a1), .byteenable(be1), .writedata(wd1),
    .waitrequest(wq1), .readdata(rdd1), .readdatavalid(rdv1),
    .chipselect2(cs2), .read2(rd2), .write2(wr2),
    .address2(a2), .byteenable2(be2), .writedata2(wd2),
    .waitrequest2(wq2), .readdata2(rdd2), .readdatavalid2(rdv2),
    .busy(busy), .range_err(rerr)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
  } resp_t;

  typedef struct {
    bit          c1, r1, w1;
    logic [4:0]  ad1;
    logic [3:0]  b1;
    logic [31:0] d1;
    bit          e1;
    logic [31:0] x1;
    bit          c2, r2, w2;
    logic [4:0]  ad2;
    logic [3:0]  b2;
    logic [31:0] d2;
    bit          e2;
    logic [31:0] x2;
  } vec_t;

  resp_t       q1[$], q2[$];
  logic [31:0] model[DEP];
  int          cyc, since, checks, errors;
  bit          col_prev, rerr_m, use1, use2;
  logic [31:0] x1, x2, last1, last2;
  vec_t        tbl[13];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(logic [31:0] old,
                                        logic [31:0] wd,
                                        logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  task automatic idle();
    cs1 = 0; rd1 = 0; wr1 = 0; a1 = '0; be1 = '0; wd1 = '0;
    cs2 = 0; rd2 = 0; wr2 = 0; a2 = '0; be2 = '0; wd2 = '0;
    use1 = 0; use2 = 0;
  endtask

  // One clock: check combinational stall, advance model, check outputs.
  task automatic step();
    bit ready, col, ac1, ac2;
    logic [31:0] r;
    #1;
    ready = since >= 1 + DEP;
    col = ready && cs1 && wr1 && cs2 && wr2 && a1 == a2 && !col_prev;
    chk("waitrequest", 32'(wq1), 32'(!ready));
    chk("waitrequest2", 32'(wq2), 32'(!ready || col));
    ac1 = ready && cs1 && (rd1 || wr1);
    ac2 = ready && !col && cs2 && (rd2 || wr2);
    if (ac1 && rd1 && !wr1) begin
      r = (a1 < DEP) ? model[a1[3:0]] : 32'd0;
      if (use1) r = x1;
      q1.push_back('{cyc + RL, r});
    end
    if (ac2 && rd2 && !wr2) begin
      r = (a2 < DEP) ? model[a2[3:0]] : 32'd0;
      if (use2) r = x2;
      q2.push_back('{cyc + RL, r});
    end
    if ((ac1 && a1 >= DEP) || (ac2 && a2 >= DEP)) rerr_m = 1;
    if (ac1 && wr1 && a1 < DEP)
      model[a1[3:0]] = merge(model[a1[3:0]], wd1, be1);
    if (ac2 && wr2 && a2 < DEP)
      model[a2[3:0]] = merge(model[a2[3:0]], wd2, be2);
    col_prev = col;
    @(posedge clk);
    cyc++;
    since++;
    #1;
    chk("busy", 32'(busy), 32'(since < 1 + DEP));
    chk("range_err", 32'(rerr), 32'(rerr_m));
    if (q1.size() > 0 && q1[0].due == cyc) begin
      chk("readdatavalid", 32'(rdv1), 32'd1);
      last1 = q1[0].data;
      void'(q1.pop_front());
    end else begin
      chk("readdatavalid", 32'(rdv1), 32'd0);
    end
    if (q2.size() > 0 && q2[0].due == cyc) begin
      chk("readdatavalid2", 32'(rdv2), 32'd1);
      last2 = q2[0].data;
      void'(q2.pop_front());
    end else begin
      chk("readdatavalid2", 32'(rdv2), 32'd0);
    end
    chk("readdata", rdd1, last1);
    chk("readdata2", rdd2, last2);
  endtask

  task automatic do_reset(int n);
    reset_n = 0;
    #1;
    chk("rst busy", 32'(busy), 32'd1);
    chk("rst waitrequest", 32'(wq1), 32'd1);
    chk("rst waitrequest2", 32'(wq2), 32'd1);
    chk("rst readdatavalid", 32'(rdv1), 32'd0);
    chk("rst readdatavalid2", 32'(rdv2), 32'd0);
    chk("rst readdata", rdd1, 32'd0);
    chk("rst readdata2", rdd2, 32'd0);
    chk("rst range_err", 32'(rerr), 32'd0);
    q1.delete();
    q2.delete();
    since = 0;
    col_prev = 0;
    rerr_m = 0;
    last1 = 0;
    last2 = 0;
    for (int i = 0; i < DEP; i++) model[i] = '0;
    repeat (n) @(posedge clk);
    #1;
    reset_n = 1;
  endtask

  task automatic read_all_zero();
    for (int i = 0; i < DEP; i++) begin
      idle();
      cs1 = 1; rd1 = 1; a1 = AW'(i);
      use1 = 1; x1 = 32'd0;
      step();
    end
    idle();
    repeat (3) step();
  endtask

  initial begin
    checks = 0; errors = 0; cyc = 0; since = 0;
    col_prev = 0; rerr_m = 0; last1 = 0; last2 = 0;
    x1 = 0; x2 = 0;
    idle();

    tbl[0]  = '{1,0,1,5'd5,4'b0101,32'hAABBCCDD,0,0,
                0,0,0,5'd0,4'h0,32'h0,0,0};
    tbl[1]  = '{1,1,0,5'd5,4'h0,32'h0,1,32'h00BB00DD,
                0,0,0,5'd0,4'h0,32'h0,0,0};
    tbl[2]  = '{0,0,0,5'd0,4'h0,32'h0,0,0,
                0,0,0,5'd0,4'h0,32'h0,0,0};
    tbl[3]  = '{1,0,1,5'd3,4'hF,32'h11111111,0,0,
                1,0,1,5'd3,4'hF,32'h22222222,0,0};
    tbl[4]  = '{0,0,0,5'd0,4'h0,32'h0,0,0,
                1,0,1,5'd3,4'hF,32'h22222222,0,0};
    tbl[5]  = '{1,1,0,5'd3,4'h0,32'h0,1,32'h22222222,
                0,0,0,5'd0,4'h0,32'h0,0,0};
    tbl[6]  = '{1,0,1,5'd7,4'hF,32'h5A5A5A5A,0,0,
                1,1,0,5'd7,4'h0,32'h0,1,32'h0};
    tbl[7]  = '{0,0,0,5'd0,4'h0,32'h0,0,0,
                1,1,0,5'd7,4'h0,32'h0,1,32'h5A5A5A5A};
    tbl[8]  = '{1,0,1,5'd7,4'h0,32'hFFFFFFFF,0,0,
                1,1,0,5'd7,4'h0,32'h0,1,32'h5A5A5A5A};
    tbl[9]  = '{0,0,0,5'd0,4'h0,32'h0,0,0,
                1,1,0,5'd16,4'h0,32'h0,1,32'h0};
    tbl[10] = '{1,1,0,5'd7,4'h0,32'h0,1,32'h5A5A5A5A,
                1,1,0,5'd5,4'h0,32'h0,1,32'h00BB00DD};
    tbl[11] = '{1,1,1,5'd2,4'hF,32'h12345678,0,0,
                0,0,0,5'd0,4'h0,32'h0,0,0};
    tbl[12] = '{0,0,0,5'd0,4'h0,32'h0,0,0,
                1,1,0,5'd2,4'h0,32'h0,1,32'h12345678};

    @(posedge clk);
    #1;
    do_reset(2);
    repeat (1 + DEP) step();
    read_all_zero();

    foreach (tbl[i]) begin
      cs1 = tbl[i].c1; rd1 = tbl[i].r1; wr1 = tbl[i].w1;
      a1 = tbl[i].ad1; be1 = tbl[i].b1; wd1 = tbl[i].d1;
      use1 = tbl[i].e1; x1 = tbl[i].x1;
      cs2 = tbl[i].c2; rd2 = tbl[i].r2; wr2 = tbl[i].w2;
      a2 = tbl[i].ad2; be2 = tbl[i].b2; wd2 = tbl[i].d2;
      use2 = tbl[i].e2; x2 = tbl[i].x2;
      step();
    end
    idle();
    repeat (3) step();

    // Random traffic; a stalled s2 master holds its request.
    for (int n = 0; n < 400; n++) begin
      use1 = 0; use2 = 0;
      cs1 = ($urandom_range(0, 3) != 0);
      rd1 = $urandom_range(0, 1) == 1;
      wr1 = $urandom_range(0, 1) == 1;
      a1 = ($urandom_range(0, 9) == 0) ? AW'(16 + $urandom_range(0, 15))
                                       : AW'($urandom_range(0, 5));
      be1 = 4'($urandom_range(0, 15));
      wd1 = $urandom;
      if (!col_prev) begin
        cs2 = ($urandom_range(0, 3) != 0);
        rd2 = $urandom_range(0, 1) == 1;
        wr2 = $urandom_range(0, 1) == 1;
        a2 = ($urandom_range(0, 9) == 0) ? AW'(16 + $urandom_range(0, 15))
                                         : AW'($urandom_range(0, 5));
        be2 = 4'($urandom_range(0, 15));
        wd2 = $urandom;
      end
      step();
    end
    idle();
    repeat (3) step();

    // Read in flight when reset hits: no response may appear.
    cs1 = 1; rd1 = 1; a1 = 5'd1;
    cs2 = 1; rd2 = 1; a2 = 5'd2;
    step();
    idle();
    do_reset(2);
    cs1 = 1; rd1 = 1; a1 = 5'd4;
    repeat (9) step();
    do_reset(1);
    cs1 = 1; rd1 = 1; a1 = 5'd4;
    use1 = 1; x1 = 32'd0;
    repeat (1 + DEP) step();
    read_all_zero();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
